// File: rtl/lcd_time_refresh_ctrl_pkg.sv
// rtl/lcd_time_refresh_ctrl_pkg.sv - shared states, LCD command constants and slot helpers
package lcd_time_refresh_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_PWRUP,
        ST_INIT,
        ST_IDLE,
        ST_ADDR,
        ST_CHAR
    } state_t;

    localparam logic [7:0] CMD_FUNC_SET = 8'h38;
    localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
    localparam logic [7:0] CMD_ENTRY    = 8'h06;
    localparam logic [7:0] CMD_CLEAR    = 8'h01;
    localparam logic [7:0] CHAR_COLON   = 8'h3A;

    localparam int INIT_LEN    = 4;
    localparam int FRAME_CHARS = 8;
    localparam int IDX_W       = 3;

    function automatic logic [7:0] init_cmd(input logic [IDX_W-1:0] idx);
        case (idx)
            3'd0:    init_cmd = CMD_FUNC_SET;
            3'd1:    init_cmd = CMD_DISP_ON;
            3'd2:    init_cmd = CMD_ENTRY;
            default: init_cmd = CMD_CLEAR;
        endcase
    endfunction

    // Character positions 2 and 5 of "HH:MM:SS" are separators, the rest are digits.
    function automatic logic is_colon(input logic [IDX_W-1:0] idx);
        is_colon = (idx == 3'd2) || (idx == 3'd5);
    endfunction

    function automatic logic [3:0] digit_sel(input logic [23:0] bcd, input logic [IDX_W-1:0] idx);
        case (idx)
            3'd0:    digit_sel = bcd[23:20];
            3'd1:    digit_sel = bcd[19:16];
            3'd3:    digit_sel = bcd[15:12];
            3'd4:    digit_sel = bcd[11:8];
            3'd6:    digit_sel = bcd[7:4];
            default: digit_sel = bcd[3:0];
        endcase
    endfunction

endpackage

// File: rtl/bcd_to_ascii.sv
// rtl/bcd_to_ascii.sv - BCD digit to ASCII character, saturating at '9'
module bcd_to_ascii (
    input  logic [3:0] digit,
    output logic [7:0] ascii
);

    assign ascii = (digit > 4'd8) ? 8'h39 : {4'h3, digit};

endmodule

// File: rtl/lcd_time_refresh_ctrl.sv
// rtl/lcd_time_refresh_ctrl.sv - HD44780 init sequencer and HH:MM:SS refresh engine
module lcd_time_refresh_ctrl
    import lcd_time_refresh_ctrl_pkg::*;
#(
    parameter int         PWRUP_CYC    = 750000,
    parameter int         SLOT_CYC     = 2500,
    parameter int         EN_CYC       = 25,
    parameter int         CLR_SLOT_CYC = 100000,
    parameter logic [7:0] LINE_ADDR    = 8'h80
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [23:0] time_bcd,
    output logic        lcd_rs,
    output logic        lcd_rw,
    output logic        lcd_en,
    output logic [7:0]  lcd_data,
    output logic        init_done,
    output logic        frame_done
);

    localparam int MAX_CYC = (PWRUP_CYC > CLR_SLOT_CYC) ? PWRUP_CYC : CLR_SLOT_CYC;
    localparam int CW      = $clog2(MAX_CYC);

    localparam logic [CW-1:0]    PWRUP_LAST = CW'(PWRUP_CYC - 1);
    localparam logic [CW-1:0]    SLOT_LAST  = CW'(SLOT_CYC - 1);
    localparam logic [CW-1:0]    CLR_LAST   = CW'(CLR_SLOT_CYC - 1);
    localparam logic [CW-1:0]    EN_FIRST   = CW'(2);
    localparam logic [CW-1:0]    EN_LAST    = CW'(EN_CYC + 1);
    localparam logic [IDX_W-1:0] INIT_LAST  = IDX_W'(INIT_LEN - 1);
    localparam logic [IDX_W-1:0] CHAR_LAST  = IDX_W'(FRAME_CHARS - 1);

    state_t           state, state_nx;
    logic [CW-1:0]    cnt, cnt_nx, slot_last;
    logic [IDX_W-1:0] idx, idx_nx;
    logic [23:0]      snap;
    logic [3:0]       digit;
    logic [7:0]       digit_ascii, slot_data;
    logic             slot_rs, in_slot, in_slot_nx, slot_end;

    assign digit  = digit_sel(snap, idx);
    assign lcd_rw = 1'b0;

    bcd_to_ascii u_bcd_to_ascii (
        .digit (digit),
        .ascii (digit_ascii)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_PWRUP;
            cnt   <= '0;
            idx   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            idx   <= idx_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        idx_nx    = idx;
        slot_rs   = 1'b0;
        slot_data = LINE_ADDR;
        slot_last = (state == ST_INIT && idx == INIT_LAST) ? CLR_LAST : SLOT_LAST;
        in_slot   = (state == ST_INIT) || (state == ST_ADDR) || (state == ST_CHAR);
        slot_end  = (cnt == slot_last);

        if (state == ST_INIT) begin
            slot_data = init_cmd(idx);
        end else if (state == ST_CHAR) begin
            slot_rs   = 1'b1;
            slot_data = is_colon(idx) ? CHAR_COLON : digit_ascii;
        end

        if (in_slot) begin
            cnt_nx = slot_end ? '0 : cnt + 1'b1;
        end

        case (state)
            ST_PWRUP: begin
                if (cnt == PWRUP_LAST) begin
                    state_nx = ST_INIT;
                    cnt_nx   = '0;
                    idx_nx   = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            ST_INIT: begin
                if (slot_end) begin
                    if (idx == INIT_LAST) state_nx = ST_IDLE;
                    else                  idx_nx   = idx + 1'b1;
                end
            end
            ST_IDLE: begin
                cnt_nx = '0;
                if (enable) state_nx = ST_ADDR;
            end
            ST_ADDR: begin
                if (slot_end) begin
                    state_nx = ST_CHAR;
                    idx_nx   = '0;
                end
            end
            ST_CHAR: begin
                if (slot_end) begin
                    if (idx == CHAR_LAST) state_nx = ST_IDLE;
                    else                  idx_nx   = idx + 1'b1;
                end
            end
            default: begin
                state_nx = ST_PWRUP;
                cnt_nx   = '0;
                idx_nx   = '0;
            end
        endcase

        in_slot_nx = (state_nx == ST_INIT) || (state_nx == ST_ADDR) || (state_nx == ST_CHAR);
    end

    // Strobes are decoded from the next-state values so they line up with cnt without a lag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lcd_rs     <= 1'b0;
            lcd_data   <= 8'h00;
            lcd_en     <= 1'b0;
            init_done  <= 1'b0;
            frame_done <= 1'b0;
            snap       <= '0;
        end else begin
            if (in_slot && cnt == '0) begin
                lcd_rs   <= slot_rs;
                lcd_data <= slot_data;
            end
            if (state == ST_ADDR && cnt == '0) begin
                snap <= time_bcd;
            end
            lcd_en     <= in_slot_nx && (cnt_nx >= EN_FIRST) && (cnt_nx <= EN_LAST);
            frame_done <= (state_nx == ST_CHAR) && (idx_nx == CHAR_LAST) && (cnt_nx == SLOT_LAST);
            if (state_nx == ST_IDLE) begin
                init_done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lcd_time_refresh_ctrl.sv
// tb/tb_lcd_time_refresh_ctrl.sv - directed and randomized bench for lcd_time_refresh_ctrl
module tb_lcd_time_refresh_ctrl;

    localparam int PWRUP_CYC    = 4;
    localparam int SLOT_CYC     = 8;
    localparam int EN_CYC       = 2;
    localparam int CLR_SLOT_CYC = 20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [23:0] time_bcd = 24'h0;
    logic        lcd_rs, lcd_rw, lcd_en, init_done, frame_done;
    logic [7:0]  lcd_data;

    lcd_time_refresh_ctrl #(
        .PWRUP_CYC    (PWRUP_CYC),
        .SLOT_CYC     (SLOT_CYC),
        .EN_CYC       (EN_CYC),
        .CLR_SLOT_CYC (CLR_SLOT_CYC),
        .LINE_ADDR    (8'h80)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .time_bcd   (time_bcd),
        .lcd_rs     (lcd_rs),
        .lcd_rw     (lcd_rw),
        .lcd_en     (lcd_en),
        .lcd_data   (lcd_data),
        .init_done  (init_done),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [8:0] ev_q[$];
    int         rise_q[$];
    int         width_q[$];
    int         fd_q[$];
    int         tests = 0;
    int         fails = 0;

    initial begin : monitor
        logic en_prev;
        int   w;
        en_prev = 1'b0;
        w = 0;
        forever begin
            @(negedge clk);
            if (lcd_en && !en_prev) begin
                ev_q.push_back({lcd_rs, lcd_data});
                rise_q.push_back(cyc);
                w = 1;
            end else if (lcd_en) begin
                w++;
            end else if (en_prev) begin
                width_q.push_back(w);
            end
            if (frame_done) fd_q.push_back(cyc);
            en_prev = lcd_en;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic clear_q();
        ev_q.delete();
        rise_q.delete();
        width_q.delete();
        fd_q.delete();
    endtask

    task automatic wait_ev(input int n, input int budget);
        int t;
        t = 0;
        while (ev_q.size() < n && t < budget) begin
            tick(1);
            t++;
        end
        if (ev_q.size() < n) chk("ev_timeout", ev_q.size(), n);
    endtask

    task automatic wait_fd(input int n, input int budget);
        int t;
        t = 0;
        while (fd_q.size() < n && t < budget) begin
            tick(1);
            t++;
        end
        if (fd_q.size() < n) chk("frame_done_timeout", fd_q.size(), n);
    endtask

    // Expected glyph for "HH:MM:SS" position pos, straight from the digit rules.
    function automatic logic [7:0] exp_char(input logic [23:0] bcd, input int pos);
        int k, d;
        if (pos == 2 || pos == 5) return 8'h3A;
        k = pos - pos / 3;
        d = int'((bcd >> (20 - 4 * k)) & 24'hF);
        return (d > 8) ? 8'h39 : 8'(48 + d);
    endfunction

    task automatic check_frame(input string tag, input logic [23:0] bcd, input int base);
        logic [8:0] e;
        for (int i = 0; i < 9; i++) begin
            e = (i == 0) ? {1'b0, 8'h80} : {1'b1, exp_char(bcd, i - 1)};
            if (base + i < ev_q.size()) chk(tag, 32'(ev_q[base + i]), 32'(e));
            else                        chk({tag, "_missing"}, ev_q.size(), base + 9);
        end
    endtask

    task automatic check_widths(input string tag);
        foreach (width_q[i]) chk(tag, width_q[i], EN_CYC);
    endtask

    task automatic release_and_init(input string tag);
        int rel, t;
        logic [7:0] cmds[4];
        cmds = '{8'h38, 8'h0C, 8'h06, 8'h01};
        clear_q();
        rst_n = 1'b1;
        rel = cyc;
        t = 0;
        while (!init_done && t < 200) begin
            tick(1);
            t++;
        end
        chk({tag, "_init_done_cycle"}, cyc - rel, 4 + 24 + 20);
        tick(20);
        chk({tag, "_init_count"}, ev_q.size(), 4);
        for (int i = 0; i < 4 && i < ev_q.size(); i++) chk({tag, "_init_cmd"}, 32'(ev_q[i]), {24'h0, 1'b0, cmds[i]});
        if (rise_q.size() > 0) chk({tag, "_first_en_cycle"}, rise_q[0] - rel, 6);
        check_widths({tag, "_en_width"});
        chk({tag, "_init_done_sticky"}, init_done, 1);
    endtask

    task automatic run_frame(input string tag, input logic [23:0] bcd);
        clear_q();
        time_bcd = bcd;
        enable = 1'b1;
        tick(1);
        enable = 1'b0;
        wait_fd(1, 200);
        tick(12);
        chk({tag, "_count"}, ev_q.size(), 9);
        check_frame(tag, bcd, 0);
        chk({tag, "_fd_count"}, fd_q.size(), 1);
        if (fd_q.size() > 0 && rise_q.size() > 0)
            chk({tag, "_fd_cycle"}, fd_q[0] - rise_q[0], 9 * SLOT_CYC - 1 - 2);
        check_widths({tag, "_en_width"});
    endtask

    initial begin
        logic [23:0] r;

        tick(3);
        chk("rst_rs", lcd_rs, 0);
        chk("rst_rw", lcd_rw, 0);
        chk("rst_en", lcd_en, 0);
        chk("rst_data", lcd_data, 0);
        chk("rst_init_done", init_done, 0);
        chk("rst_frame_done", frame_done, 0);

        release_and_init("init");

        run_frame("frame_123456", 24'h123456);
        run_frame("saturate", 24'hFA9B00);
        for (int k = 0; k < 4; k++) begin
            r = 24'($urandom);
            run_frame("random", r);
        end

        clear_q();
        time_bcd = 24'h235959;
        enable = 1'b1;
        wait_ev(5, 200);
        time_bcd = 24'h000000;
        wait_fd(2, 400);
        enable = 1'b0;
        tick(20);
        chk("snap_count", ev_q.size(), 18);
        check_frame("snap_frame1", 24'h235959, 0);
        check_frame("snap_frame2", 24'h000000, 9);
        if (rise_q.size() > 9) chk("snap_gap", rise_q[9] - rise_q[0], 9 * SLOT_CYC + 1);

        clear_q();
        r = 24'($urandom);
        time_bcd = r;
        enable = 1'b1;
        wait_ev(7, 200);
        enable = 1'b0;
        tick(150);
        chk("drop_count", ev_q.size(), 9);
        chk("drop_fd_count", fd_q.size(), 1);
        check_frame("drop_frame", r, 0);

        clear_q();
        time_bcd = 24'h101010;
        enable = 1'b1;
        tick(1);
        enable = 1'b0;
        wait_ev(4, 200);
        chk("midrst_en_before", lcd_en, 1);
        chk("midrst_rw", lcd_rw, 0);
        rst_n = 1'b0;
        #1;
        chk("midrst_en_async", lcd_en, 0);
        chk("midrst_init_done", init_done, 0);
        tick(2);
        release_and_init("reinit");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
